// File: rtl/sseg_scan_mux_if.sv
// rtl/sseg_scan_mux_if.sv - shadow-write/commit bus and scanned display outputs of sseg_scan_mux
interface sseg_scan_mux_if;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic       commit;
   logic       commit_done;
   logic       frame_tick;
   logic [3:0] an;
   logic [7:0] sseg;

   modport master (
      output wr_en, wr_addr, wr_data, commit,
      input  commit_done, frame_tick, an, sseg
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, commit,
      output commit_done, frame_tick, an, sseg
   );
endinterface

// File: rtl/sseg_scan_mux.sv
// rtl/sseg_scan_mux.sv - tear-free 4-digit common-anode scan driver; SSEG_BLANK_EN adds per-slot blanking
module sseg_scan_mux #(
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   sseg_scan_mux_if.slave bus
);
   localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLANK_LEN = CW'(BLANK_CYCLES);
`ifdef SSEG_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif
   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_DRIVE = 1'b1;
   localparam logic [0:0] ST_INIT  = BLANK_ON ? ST_BLANK : ST_DRIVE;

   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    idx;
   logic          pending;
   logic [0:0]    state, state_nxt;
   logic [7:0]    shadow [4];
   logic [7:0]    active [4];
   logic          boundary, apply;

   always_comb begin
      boundary  = (idx == 2'd3) && (cnt == CNT_LAST);
      apply     = boundary && (pending || bus.commit);
      cnt_nxt   = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      state_nxt = (BLANK_ON && (cnt_nxt < BLANK_LEN)) ? ST_BLANK : ST_DRIVE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt             <= '0;
         idx             <= 2'd0;
         pending         <= 1'b0;
         state           <= ST_INIT;
         bus.an          <= 4'b1111;
         bus.sseg        <= 8'hFF;
         bus.commit_done <= 1'b0;
         bus.frame_tick  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            shadow[i] <= 8'hFF;
            active[i] <= 8'hFF;
         end
      end else begin
         cnt   <= cnt_nxt;
         state <= state_nxt;
         if (cnt == CNT_LAST)
            idx <= idx + 2'd1;

         // Nonblocking copy: a write landing in the boundary cycle misses this commit.
         if (apply) begin
            for (int i = 0; i < 4; i++)
               active[i] <= shadow[i];
         end
         if (bus.wr_en)
            shadow[bus.wr_addr] <= bus.wr_data;

         if (boundary)
            pending <= 1'b0;
         else if (bus.commit)
            pending <= 1'b1;

         bus.commit_done <= apply;
         bus.frame_tick  <= boundary;

         if (state == ST_BLANK) begin
            bus.an   <= 4'b1111;
            bus.sseg <= 8'hFF;
         end else begin
            bus.an   <= ~(4'b0001 << idx);
            bus.sseg <= active[idx];
         end
      end
   end
endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb/tb_sseg_scan_mux.sv - randomized self-checking bench for sseg_scan_mux (PRESCALE=8, BLANK_CYCLES=2)
module tb_sseg_scan_mux;
   localparam int P     = 8;
   localparam int B     = 2;
   localparam int FRAME = 4 * P;
`ifdef SSEG_BLANK_EN
   localparam bit BLANK_ON = 1'b1;
`else
   localparam bit BLANK_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   sseg_scan_mux_if bus ();

   sseg_scan_mux #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int t = 0;
   logic [7:0] m_shadow [4];
   logic [7:0] m_active [4];
   bit         m_pending;
   logic [3:0] exp_an;
   logic [7:0] exp_sseg;
   logic       exp_ft, exp_cd;
   logic [13:0] obs, expv;

   // Reference: position within the frame is plain cycle arithmetic from reset release.
   task automatic tick();
      int pos, slot, ofs;
      logic [3:0] onehot;
      bit blank, bnd;
      if (rst) begin
         exp_an = 4'hF; exp_sseg = 8'hFF; exp_ft = 1'b0; exp_cd = 1'b0;
         for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 8'hFF;
            m_active[i] = 8'hFF;
         end
         m_pending = 1'b0;
      end else begin
         pos    = t % FRAME;
         slot   = pos / P;
         ofs    = pos % P;
         blank  = BLANK_ON && (ofs < B);
         onehot = 4'b0001 << slot;
         exp_an   = blank ? 4'hF : ~onehot;
         exp_sseg = blank ? 8'hFF : m_active[slot];
         bnd    = (pos == FRAME - 1);
         exp_ft = bnd;
         exp_cd = bnd && (m_pending || bus.commit);
         if (exp_cd)
            for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
         if (bnd) m_pending = 1'b0;
         else if (bus.commit) m_pending = 1'b1;
         if (bus.wr_en) m_shadow[bus.wr_addr] = bus.wr_data;
         t++;
      end
      @(posedge clk);
      #1;
      if (rst) t = 0;
      bus.wr_en = 1'b0;
      bus.commit = 1'b0;
      obs  = {bus.an, bus.sseg, bus.frame_tick, bus.commit_done};
      expv = {exp_an, exp_sseg, exp_ft, exp_cd};
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
   endtask

   task automatic test_reset();
      int ticks = 0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({bus.an, bus.sseg, bus.commit_done, bus.frame_tick} !== {4'hF, 8'hFF, 2'b00}) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", {bus.an, bus.sseg, bus.commit_done, bus.frame_tick}, {4'hF, 8'hFF, 2'b00});
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 70; i++) begin
         tick();
         ticks += bus.frame_tick;
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL reset_scan t=%0d: got %h expected %h", t, obs, expv);
         end
      end
      checks++;
      if (ticks != 2) begin
         errors++;
         $display("FAIL reset_frame_ticks: got %0d expected 2", ticks);
      end
   endtask

   task automatic test_write_commit();
      int cds = 0;
      bit seen0 = 0, seen1 = 0;
      wr(2'd0, 8'hC0); tick();
      wr(2'd1, 8'hF9); tick();
      while (t % FRAME != 2 * P + 3) tick();
      bus.commit = 1'b1;
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         cds += bus.commit_done;
         if (cds > 0 && bus.an == 4'b1110 && bus.sseg == 8'hC0) seen0 = 1;
         if (cds > 0 && bus.an == 4'b1101 && bus.sseg == 8'hF9) seen1 = 1;
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL write_commit t=%0d: got %h expected %h", t, obs, expv);
         end
         if (bus.commit_done) begin
            checks++;
            if (bus.frame_tick !== 1'b1) begin
               errors++;
               $display("FAIL commit_tick_align: got %b expected 1", bus.frame_tick);
            end
         end
      end
      checks++;
      if ({cds == 1, seen0, seen1} !== 3'b111) begin
         errors++;
         $display("FAIL commit_shown: got done=%0d c0=%0d f9=%0d expected 1 1 1", cds, seen0, seen1);
      end
   endtask

   task automatic test_write_no_commit();
      int cds = 0;
      wr(2'd2, 8'hA4); tick();
      for (int i = 0; i < 3 * FRAME; i++) begin
         tick();
         cds += bus.commit_done;
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL no_commit t=%0d: got %h expected %h", t, obs, expv);
         end
         if (bus.an == 4'b1011) begin
            checks++;
            if (bus.sseg !== 8'hFF) begin
               errors++;
               $display("FAIL no_commit_digit2: got %h expected ff", bus.sseg);
            end
         end
      end
      checks++;
      if (cds != 0) begin
         errors++;
         $display("FAIL no_commit_done: got %0d expected 0", cds);
      end
   endtask

   task automatic test_boundary_collision();
      bit old_seen = 0, new_seen = 0, new_early = 0;
      wr(2'd0, 8'h82); tick();
      while (t % FRAME != FRAME - 1) tick();
      wr(2'd0, 8'h99);
      bus.commit = 1'b1;
      for (int i = 0; i < FRAME + 4; i++) begin
         tick();
         if (bus.an == 4'b1110 && bus.sseg == 8'h82) old_seen = 1;
         if (bus.sseg == 8'h99) new_early = 1;
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL collision t=%0d: got %h expected %h", t, obs, expv);
         end
      end
      bus.commit = 1'b1;
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         if (bus.an == 4'b1110 && bus.sseg == 8'h99) new_seen = 1;
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL collision_recommit t=%0d: got %h expected %h", t, obs, expv);
         end
      end
      checks++;
      if ({old_seen, new_early, new_seen} !== 3'b101) begin
         errors++;
         $display("FAIL collision_values: got old=%0d early=%0d new=%0d expected 1 0 1", old_seen, new_early, new_seen);
      end
   endtask

   task automatic test_blanking();
      int dark = 0;
      while (t % FRAME != 0) tick();
      for (int i = 0; i < FRAME; i++) begin
         tick();
         if (bus.an == 4'b1111) dark++;
      end
      checks++;
      if (dark != (BLANK_ON ? 4 * B : 0)) begin
         errors++;
         $display("FAIL blank_cycles: got %0d expected %0d", dark, BLANK_ON ? 4 * B : 0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) wr(2'($urandom_range(0, 3)), 8'($urandom));
         if ($urandom_range(0, 19) == 0) bus.commit = 1'b1;
         tick();
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL random t=%0d: got %h expected %h", t, obs, expv);
         end
      end
   endtask

   task automatic test_reset_mid();
      int cds = 0;
      while (t % FRAME != 3) tick();
      wr(2'd3, 8'h8E);
      bus.commit = 1'b1;
      tick();
      while (t % FRAME != 3 * P + 2) tick();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < FRAME + 8; i++) begin
         tick();
         cds += bus.commit_done;
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL reset_mid t=%0d: got %h expected %h", t, obs, expv);
         end
         if (bus.an != 4'b1111) begin
            checks++;
            if (bus.sseg !== 8'hFF) begin
               errors++;
               $display("FAIL reset_mid_active: got %h expected ff", bus.sseg);
            end
         end
      end
      checks++;
      if (cds != 0) begin
         errors++;
         $display("FAIL reset_mid_done: got %0d expected 0", cds);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 8'h00; bus.commit = 1'b0;
      test_reset();
      test_write_commit();
      test_write_no_commit();
      test_boundary_collision();
      test_blanking();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
